// File: rtl/ddls_pkg.sv
// Shared types and result-word layout for the DDLS bit-scan responder.
package ddls_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int POP_LSB  = 0;
    localparam int LZC_LSB  = 8;
    localparam int LOW_LSB  = 16;
    localparam int ZERO_BIT = 24;
    localparam int PAR_BIT  = 25;

    typedef struct packed {
        logic [5:0] pad;
        logic       par;
        logic       zero;
        logic [7:0] low;
        logic [7:0] lzc;
        logic [7:0] pop;
    } result_t;

    function automatic logic [31:0] pack_result(input logic [7:0] pop,
                                                input logic [7:0] lzc,
                                                input logic [7:0] low,
                                                input logic       zero,
                                                input logic       par);
        result_t r;
        r      = '0;
        r.pop  = pop;
        r.lzc  = lzc;
        r.low  = low;
        r.zero = zero;
        r.par  = par;
        return r;
    endfunction

endpackage

// File: rtl/ddls_bit_scan_responder_chunk_scan.sv
// Combinational scan of one CHUNK_W-bit slice, evaluated MSB to LSB.
module ddls_chunk_scan
    import ddls_pkg::*;
#(
    parameter int CHUNK_W = 4,
    parameter int CNT_W   = 6
) (
    input  logic [CHUNK_W-1:0] chunk,
    input  logic               seen_in,
    input  logic [CNT_W-1:0]   base,
    output logic [CNT_W-1:0]   ones,
    output logic [CNT_W-1:0]   zeros,
    output logic               seen_out,
    output logic [CNT_W-1:0]   low_pos,
    output logic               found
);

    always_comb begin
        ones     = '0;
        zeros    = '0;
        low_pos  = '0;
        seen_out = seen_in;
        found    = 1'b0;
        // base is the absolute position of chunk's MSB; later ones overwrite low_pos
        for (int j = 0; j < CHUNK_W; j++) begin
            if (chunk[CHUNK_W-1-j]) begin
                ones     = ones + CNT_W'(1);
                seen_out = 1'b1;
                found    = 1'b1;
                low_pos  = base - CNT_W'(j);
            end else if (!seen_out) begin
                zeros = zeros + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ddls_bit_scan_responder.sv
// DDLS responder: accepts a word on valid, scans it CHUNK_W bits per cycle and
// presents popcount / leading zeros / lowest set bit / zero / parity on data_out.
module ddls_bit_scan_responder
    import ddls_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              busy,
    output logic [31:0]       data_out
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam logic [CNT_W-1:0] TOP_POS  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STEP     = CNT_W'(CHUNK_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] NONE_POS = CNT_W'(DATA_W);

    state_t state, state_next;
    logic              armed;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  pop, lzc, low, pos, cnt;
    logic              seen;

    logic              accept, last;
    logic [CNT_W-1:0]  c_ones, c_zeros, c_low;
    logic              c_seen, c_found;
    logic [CNT_W-1:0]  pop_next, lzc_next, low_next;

    ddls_chunk_scan #(
        .CHUNK_W(CHUNK_W),
        .CNT_W  (CNT_W)
    ) u_chunk (
        .chunk   (shreg[DATA_W-1 -: CHUNK_W]),
        .seen_in (seen),
        .base    (pos),
        .ones    (c_ones),
        .zeros   (c_zeros),
        .seen_out(c_seen),
        .low_pos (c_low),
        .found   (c_found)
    );

    assign pop_next = pop + c_ones;
    assign lzc_next = lzc + c_zeros;
    assign low_next = c_found ? c_low : low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid && armed) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                if (valid && armed) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            default: state_next = IDLE;
        endcase
        // clear overrides everything, including an accept in the same cycle
        if (clear) begin
            state_next = IDLE;
            accept     = 1'b0;
            last       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b1;
            shreg    <= '0;
            pop      <= '0;
            lzc      <= '0;
            low      <= '0;
            pos      <= '0;
            cnt      <= '0;
            seen     <= 1'b0;
            data_out <= '0;
        end else begin
            if (accept)      armed <= 1'b0;
            else if (!valid) armed <= 1'b1;

            if (accept) begin
                shreg <= data_in;
                pop   <= '0;
                lzc   <= '0;
                low   <= '0;
                seen  <= 1'b0;
                pos   <= TOP_POS;
                cnt   <= '0;
            end else if (state == SCAN && !clear) begin
                shreg <= shreg << CHUNK_W;
                pop   <= pop_next;
                lzc   <= lzc_next;
                low   <= low_next;
                seen  <= c_seen;
                pos   <= pos - STEP;
                cnt   <= cnt + CNT_W'(1);
            end

            // final chunk's contribution is folded in combinationally at DONE entry
            if (clear || accept) begin
                data_out <= '0;
            end else if (last) begin
                data_out <= pack_result(8'(pop_next), 8'(lzc_next),
                                        c_seen ? 8'(low_next) : 8'(NONE_POS),
                                        !c_seen, pop_next[0]);
            end
        end
    end

endmodule

// File: tb/tb_ddls_bit_scan_responder.sv
// Bench for ddls_bit_scan_responder: three instances (CHUNK_W 1, 4, 32) share stimulus.
module tb_ddls_bit_scan_responder;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid;
    logic              clear;
    logic [DATA_W-1:0] data_in;
    logic [2:0]        ready_v;
    logic [2:0]        busy_v;
    logic [31:0]       dout_a [3];

    int n_checks = 0;
    int n_errors = 0;
    int exp_lat [3] = '{32, 8, 1};
    int rises [3];
    logic [2:0] prev_busy;
    logic [31:0] w;

    always #5 clk = ~clk;

    ddls_bit_scan_responder #(.DATA_W(DATA_W), .CHUNK_W(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .clear(clear), .data_in(data_in),
        .ready(ready_v[0]), .busy(busy_v[0]), .data_out(dout_a[0]));

    ddls_bit_scan_responder #(.DATA_W(DATA_W), .CHUNK_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .clear(clear), .data_in(data_in),
        .ready(ready_v[1]), .busy(busy_v[1]), .data_out(dout_a[1]));

    ddls_bit_scan_responder #(.DATA_W(DATA_W), .CHUNK_W(32)) dut_c32 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .clear(clear), .data_in(data_in),
        .ready(ready_v[2]), .busy(busy_v[2]), .data_out(dout_a[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result from the field definitions, independent of scan order
    function automatic logic [31:0] model(input logic [31:0] x);
        int pop, lzc, low;
        logic [31:0] r;
        pop = $countones(x);
        lzc = 32;
        for (int i = 31; i >= 0; i--) if (x[i]) begin lzc = 31 - i; break; end
        low = 32;
        for (int i = 0; i < 32; i++) if (x[i]) begin low = i; break; end
        r        = '0;
        r[7:0]   = pop[7:0];
        r[15:8]  = lzc[7:0];
        r[23:16] = low[7:0];
        r[24]    = (x == 32'h0);
        r[25]    = ^x;
        return r;
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] exp, input string tag);
        int lat [3];
        for (int i = 0; i < 3; i++) lat[i] = -1;
        data_in = x;
        valid   = 1'b1;
        tick();
        valid   = 1'b0;
        data_in = $urandom();
        check({tag, "_acc_ready"}, 32'(ready_v), 32'h0);
        check({tag, "_acc_busy"}, 32'(busy_v), 32'h7);
        for (int k = 1; k <= 40; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                if (ready_v[i] && lat[i] < 0) lat[i] = k;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(exp_lat[i]));
            check($sformatf("%s_dout%0d", tag, i), dout_a[i], exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        clear   = 1'b0;
        data_in = '0;
        #12;
        check("rst_ready", 32'(ready_v), 32'h0);
        check("rst_busy", 32'(busy_v), 32'h0);
        for (int i = 0; i < 3; i++) check($sformatf("rst_dout%0d", i), dout_a[i], 32'h0);
        rst_n = 1'b1;
        tick();

        run_op(32'h003FFFFF, 32'h00000A16, "dir_3fffff");
        run_op(32'h80000000, 32'h021F0001, "dir_msb");
        run_op(32'h00000000, 32'h01202000, "dir_zero");
        run_op(32'hFFFFFFFF, 32'h00000020, "dir_ones");

        // Held valid: exactly one operation, result stays presented
        data_in   = 32'hFFFFFFFF;
        valid     = 1'b1;
        prev_busy = busy_v;
        for (int i = 0; i < 3; i++) rises[i] = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int i = 0; i < 3; i++) if (busy_v[i] && !prev_busy[i]) rises[i]++;
            prev_busy = busy_v;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_ops%0d", i), 32'(rises[i]), 32'd1);
            check($sformatf("hold_dout%0d", i), dout_a[i], 32'h00000020);
        end
        check("hold_ready", 32'(ready_v), 32'h7);
        valid = 1'b0;
        tick();
        valid = 1'b1;
        tick();
        check("rearm_ready", 32'(ready_v), 32'h0);
        check("rearm_busy", 32'(busy_v), 32'h7);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("rearm_early", 32'(ready_v[1]), 32'h0);
        end
        check("rearm_ready8", 32'(ready_v[1]), 32'h1);
        check("rearm_dout", dout_a[1], 32'h00000020);
        valid = 1'b0;
        for (int k = 0; k < 40; k++) tick();

        // clear during scan cycle 4
        data_in = 32'h0F0F1234;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ready", 32'(ready_v), 32'h0);
        check("clr_busy", 32'(busy_v), 32'h0);
        for (int i = 0; i < 3; i++) check($sformatf("clr_dout%0d", i), dout_a[i], 32'h0);
        for (int k = 0; k < 5; k++) tick();
        check("clr_idle_busy", 32'(busy_v) | 32'(ready_v), 32'h0);

        // asynchronous reset mid-scan (CHUNK_W=32 instance is already presenting)
        data_in = 32'h00F00001;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(ready_v), 32'h0);
        check("arst_busy", 32'(busy_v), 32'h0);
        for (int i = 0; i < 3; i++) check($sformatf("arst_dout%0d", i), dout_a[i], 32'h0);
        #1;
        rst_n = 1'b1;
        tick();

        run_op(32'h00F00001, model(32'h00F00001), "post_rst");

        for (int n = 0; n < 24; n++) begin
            w = $urandom();
            if (n % 4 == 1) w = 32'h1 << $urandom_range(31, 0);
            if (n % 4 == 2) w = w & $urandom() & $urandom();
            run_op(w, model(w), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
